// File: rtl/pul_wave_player.sv
// pul_wave_player: DDS address generator and scaled DAC output stage around the pulse waveform pROM
module pul_wave_player #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ACC_W-1:0]  ftw_i,
  input  logic [ADDR_W-1:0] phase_ofs_i,
  input  logic [15:0]       burst_cnt_i,
  input  logic [8:0]        amp_i,
  output logic [ADDR_W-1:0] rom_ad_o,
  output logic              rom_ce_o,
  output logic              rom_oce_o,
  input  logic [DATA_W-1:0] rom_dout_i,
  output logic [DATA_W-1:0] dac_data_o,
  output logic              dac_valid_o,
  output logic              period_sync_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int DW = $clog2(ROM_LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t              state_q;
  logic [ACC_W-1:0]    acc_q, ftw_q;
  logic [ADDR_W-1:0]   ofs_q, rom_ad_q;
  logic [15:0]         burst_q, per_q;
  logic [8:0]          amp_q;
  logic [DW-1:0]       drn_q;
  logic                ce_q, iss_q, sync_q, done_q;
  logic [ROM_LAT:0]    vld_q, syn_q;
  logic [DATA_W-1:0]   dac_q;
  logic [ACC_W:0]      sum;
  logic [ADDR_W-1:0]   ad_nx;
  logic                last, drain_end;
  logic [DATA_W+8:0]   prod;
  assign sum       = {1'b0, acc_q} + {1'b0, ftw_q};
  assign ad_nx     = sum[ACC_W-1 -: ADDR_W] + ofs_q;
  assign last      = sum[ACC_W] && burst_q != 16'd0 && per_q == burst_q;
  assign drain_end = state_q == DRAIN && drn_q == DW'(ROM_LAT);
  assign prod      = {9'b0, rom_dout_i} * {{DATA_W{1'b0}}, amp_q};
  // Control FSM: latches config at start, steps the accumulator, counts periods, drains the pipe
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ftw_q    <= '0;
      ofs_q    <= '0;
      burst_q  <= '0;
      amp_q    <= '0;
      per_q    <= '0;
      drn_q    <= '0;
      rom_ad_q <= '0;
      ce_q     <= 1'b0;
      iss_q    <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i && !stop_i) begin
          state_q  <= RUN;
          ftw_q    <= ftw_i;
          ofs_q    <= phase_ofs_i;
          burst_q  <= burst_cnt_i;
          amp_q    <= amp_i > 9'd256 ? 9'd256 : amp_i;
          acc_q    <= '0;
          per_q    <= 16'd1;
          rom_ad_q <= phase_ofs_i;
          ce_q     <= 1'b1;
          iss_q    <= 1'b1;
          sync_q   <= 1'b1;
        end
        RUN: if (stop_i || last) begin
          state_q <= DRAIN;
          drn_q   <= '0;
          iss_q   <= 1'b0;
          sync_q  <= 1'b0;
        end else begin
          acc_q    <= sum[ACC_W-1:0];
          rom_ad_q <= ad_nx;
          per_q    <= per_q + 16'(sum[ACC_W]);
          sync_q   <= sum[ACC_W];
        end
        DRAIN: if (drain_end) begin
          state_q <= IDLE;
          ce_q    <= 1'b0;
          done_q  <= 1'b1;
        end else drn_q <= drn_q + DW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  // Sample pipe: an address aborted by stop in its own cycle never becomes a sample
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q <= '0;
      syn_q <= '0;
      dac_q <= '0;
    end else begin
      vld_q <= {vld_q[ROM_LAT-1:0], iss_q & ~stop_i};
      syn_q <= {syn_q[ROM_LAT-1:0], sync_q & ~stop_i};
      if (drain_end) dac_q <= '0;
      else if (vld_q[ROM_LAT-1]) dac_q <= prod[DATA_W+7:8];
    end
  end
  assign rom_ad_o      = rom_ad_q;
  assign rom_ce_o      = ce_q;
  assign rom_oce_o     = ce_q;
  assign busy_o        = ce_q;
  assign done_o        = done_q;
  assign dac_data_o    = dac_q;
  assign dac_valid_o   = vld_q[ROM_LAT];
  assign period_sync_o = syn_q[ROM_LAT];
endmodule
